// File: rtl/cda_pkg.sv
// Shared definitions for the fetch and memory-access stages.
package cda_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned PC_STEP = 4;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic {
    WAIT,
    HOLD
  } fetch_state_t;

  // Instruction payload handed to decode
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc4;
  } fetch_pkt_t;

  // Clear the byte-offset bits so an address is always word-aligned
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~WORD_W'(3);
  endfunction

  // Sequential PC step, wrapping modulo 2^WORD_W
  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] addr);
    return addr + WORD_W'(PC_STEP);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter with a registered zero flag; saturates at zero.
module wait_counter #(
  parameter int unsigned    W         = 4,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nx;

  // Next count: load wins over decrement, decrement stops at zero
  always_comb begin
    cnt_nx = cnt;
    if (load) begin
      cnt_nx = load_val;
    end else if (dec && (cnt != '0)) begin
      cnt_nx = cnt - W'(1);
    end
  end

  // Count register and zero flag, kept in step with each other
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= RESET_VAL;
      zero <= (RESET_VAL == '0);
    end else begin
      cnt  <= cnt_nx;
      zero <= (cnt_nx == '0);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: holds the PC, waits for the asynchronous IM to
// settle, captures the word and offers it to decode over valid/ready.
module instr_fetch
  import cda_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] im_a,
  input  logic [WORD_W-1:0] im_d,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc,
  output logic [WORD_W-1:0] if_pc4
);

  localparam logic [WORD_W-1:0] RESET_PC_AL = word_align(RESET_PC);
  localparam logic [CNT_W-1:0]  WAIT_LOAD   = CNT_W'(WAIT_CYCLES);

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic              capture;
  logic              accept;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic [WORD_W-1:0] pc;
  logic              valid_q;
  fetch_pkt_t        pkt;

  // Settle-time counter, restarted whenever a new address is issued
  wait_counter #(
    .W         (CNT_W),
    .RESET_VAL (WAIT_LOAD)
  ) u_wait_counter (
    .clk      (clk),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and datapath controls; redirect overrides capture and accept
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    accept   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (redirect) begin
      state_nx = WAIT;
      cnt_load = 1'b1;
    end else begin
      case (state)
        WAIT: begin
          if (cnt_zero) begin
            capture  = 1'b1;
            state_nx = HOLD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        HOLD: begin
          if (if_ready) begin
            accept   = 1'b1;
            cnt_load = 1'b1;
            state_nx = WAIT;
          end
        end
        default: state_nx = WAIT;
      endcase
    end
  end

  // PC, valid flag and captured payload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC_AL;
      valid_q <= 1'b0;
      pkt     <= '0;
    end else begin
      if (redirect) begin
        pc      <= word_align(redirect_pc);
        valid_q <= 1'b0;
      end else if (accept) begin
        pc      <= pc_inc(pc);
        valid_q <= 1'b0;
      end else if (capture) begin
        pkt.instr <= im_d;
        pkt.pc    <= pc;
        pkt.pc4   <= pc_inc(pc);
        valid_q   <= 1'b1;
      end
    end
  end

  assign im_a     = pc;
  assign if_valid = valid_q;
  assign if_instr = pkt.instr;
  assign if_pc    = pkt.pc;
  assign if_pc4   = pkt.pc4;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage sitting directly upstream of the instruction memory (IM). Holds the program counter and drives a stable word address into the asynchronous IM. Waits a fixed number of clock edges for IM output to settle, then captures the instruction. Presents it to decode over a valid/ready handshake; a redirect input (branch/jump) reloads the PC at any time.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `WAIT_CYCLES`, default 1: extra full clock periods the address is held before sampling `im_d`. With a 100-unit clock, 1 covers IM's 90-unit access time. Legal range 0–15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `im_a`  out  32  byte address to IM, registered; always word-aligned.
- `im_d`  in  32  instruction word from IM.
- `redirect`  in  1  load a new PC this edge.
- `redirect_pc`  in  32  target PC; bits [1:0] are ignored and forced to 0.
- `if_valid`  out  1  `if_instr`/`if_pc`/`if_pc4` hold a valid fetched instruction.
- `if_ready`  in  1  decode accepts the instruction this edge.
- `if_instr`  out  32  captured instruction.
- `if_pc`  out  32  address of `if_instr`.
- `if_pc4`  out  32  `if_pc + 4`, modulo 2^32.

## Operation
- **Internal state:** `pc[31:0]`, counter `cnt` (4 bits), and an FSM with two states.
  - WAIT: address in flight to IM.
  - HOLD: instruction presented to decode.
- **`im_a`** equals `pc` at all times. It changes only on a PC-load edge.
- **Reset (asserted, asynchronous):**
  - `pc = im_a = RESET_PC`, `cnt = WAIT_CYCLES`, state = WAIT.
  - `if_valid = 0`, `if_instr = 0`, `if_pc = 0`, `if_pc4 = 0`.
- **WAIT, per edge with `redirect = 0`:**
  - If `cnt != 0`: `cnt <= cnt - 1`.
  - If `cnt == 0`: `if_instr <= im_d`, `if_pc <= pc`, `if_pc4 <= pc + 4`, `if_valid <= 1`, go to HOLD.
- **HOLD, per edge with `redirect = 0`:**
  - If `if_ready == 1`: `pc <= pc + 4`, `if_valid <= 0`, `cnt <= WAIT_CYCLES`, go to WAIT.
  - Otherwise hold all outputs unchanged. Outputs are stable while `if_valid = 1` and `if_ready = 0`.
- **Redirect, any state:** on an edge with `redirect = 1`:
  - `pc <= {redirect_pc[31:2], 2'b00}`, `if_valid <= 0`, `cnt <= WAIT_CYCLES`, go to WAIT.
  - Redirect has priority over capture and over handshake completion. A held instruction is discarded even if `if_ready = 1` on the same edge; decode must not treat that edge as an accept.
- **Arithmetic:** the PC increment wraps, so `32'hFFFF_FFFC + 4 = 32'h0000_0000`. `if_pc4` wraps the same way.
- **Input sensitivity:** `if_ready` is ignored in WAIT. `im_d` is ignored except on the capture edge.

## Timing
- **Address-to-capture:** from the edge that loads `pc` (or reset release) to the edge that asserts `if_valid` is `WAIT_CYCLES + 1` edges.
  - The address is therefore stable for at least `WAIT_CYCLES` full periods before sampling.
  - With `WAIT_CYCLES = 0`, capture happens on the first edge after the load.
- **Throughput:** with `if_ready` tied high, one instruction per `WAIT_CYCLES + 2` cycles (default: one per 3 cycles).
- **Accept edge:** `if_valid` falls on the accept edge; `im_a` advances on the same edge.
- **Reset mid-operation:** outputs return to reset values immediately, independent of `clk`. The first capture after release follows the normal `WAIT_CYCLES + 1` edge rule.
- **`redirect` held high for several edges:** each edge reloads the PC and restarts the wait. `if_valid` stays 0 until one full wait completes after `redirect` drops.

## Structure
- **Shared package `cda_pkg`:**
  - `WORD_W = 32`.
  - `PC_STEP = 4`.
  - FSM state enum `fetch_state_t` {WAIT, HOLD}.
  - Reuse existing entries rather than redefining them.
- **Counter sub-module `wait_counter`:** one natural sub-module, a loadable down-counter with a zero flag, reusable for the data-memory stage. Everything else is inline.

## Test plan
- **Reset and first fetch:** `WAIT_CYCLES = 1`, `RESET_PC = 0`, IM preloaded with word0 = 32'h2008_0005, `if_ready = 1`.
  - During reset: `im_a = 0` and `if_valid = 0`.
  - `if_valid` rises on the 2nd edge after release, with `if_instr = 32'h2008_0005`, `if_pc = 0`, `if_pc4 = 4`.
- **Sequential stream:** `if_ready` held high for 12 cycles.
  - `if_pc` sequence is 0, 4, 8, 12, one instruction every 3 cycles.
  - `if_instr` matches IM words 0–3.
- **Backpressure:** `if_ready = 0` for 5 cycles while `if_valid = 1`.
  - `if_instr`, `if_pc` and `im_a` stay constant.
  - After `if_ready = 1`, the next `if_pc` is exactly the prior value + 4.
- **Redirect collision:** `redirect = 1`, `redirect_pc = 32'h0000_0043`, and `if_ready = 1` on the same edge while in HOLD.
  - `if_valid` drops and `im_a = 32'h0000_0040`.
  - The next `if_pc = 32'h40`; no instruction is skipped or duplicated.
- **Wrap-around:** redirect to `32'hFFFF_FFFC`, then accept one instruction.
  - `if_pc4 = 0`.
  - The next fetch has `im_a = 0` and `if_pc = 0`.
- **Asynchronous reset mid-wait:** assert `reset` between edges while `cnt = 1`.
  - `if_valid = 0` and `im_a = RESET_PC` with no clock edge.
  - After release, the fetch restarts from `RESET_PC` with full latency.
